// File: rtl/m65c02_pkg.sv
// rtl/m65c02_pkg.sv - shared codes and constants for the M65C02 register file
package m65c02_pkg;

  localparam logic [1:0] STK_HOLD = 2'b00;
  localparam logic [1:0] STK_PUSH = 2'b01;
  localparam logic [1:0] STK_POP  = 2'b10;

  localparam logic [2:0] OS_A = 3'd0;
  localparam logic [2:0] OS_X = 3'd1;
  localparam logic [2:0] OS_Y = 3'd2;
  localparam logic [2:0] OS_S = 3'd3;
  localparam logic [2:0] OS_P = 3'd4;

  localparam int P_N = 7;
  localparam int P_V = 6;
  localparam int P_B = 4;
  localparam int P_D = 3;
  localparam int P_I = 2;
  localparam int P_Z = 1;
  localparam int P_C = 0;

  localparam logic [7:0] S_RST_DEF = 8'hFF;
  localparam logic [7:0] P_RST_DEF = 8'h34;
  localparam logic [7:0] STK_PAGE  = 8'h01;

  // Bits 5 and 4 of P have no storage meaning here and always read as 1.
  function automatic logic [7:0] psw_merge(input logic [7:0] psw);
    return {psw[P_N], psw[P_V], 1'b1, 1'b1, psw[P_D], psw[P_I], psw[P_Z], psw[P_C]};
  endfunction

endpackage

// File: rtl/m65c02_stkptr.sv
// rtl/m65c02_stkptr.sv - stack pointer with TXS load, push/pop and page-1 address
module m65c02_stkptr
  import m65c02_pkg::*;
#(
  parameter logic [7:0] S_RST = S_RST_DEF
) (
  input  logic        Clk,
  input  logic        nRst,
  input  logic        Rdy,
  input  logic        Ld,
  input  logic [7:0]  Q,
  input  logic [1:0]  Stk_Op,
  output logic [7:0]  S,
  output logic [15:0] StkAdr
);

  logic [7:0] s_q;
  logic [7:0] s_d;
  logic [7:0] s_inc;

  assign s_inc = s_q + 8'd1;

  // A load (TXS) wins over any concurrent stack operation.
  always_comb begin
    s_d = s_q;
    if (Ld)                    s_d = Q;
    else if (Stk_Op == STK_PUSH) s_d = s_q - 8'd1;
    else if (Stk_Op == STK_POP)  s_d = s_inc;
  end

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst)    s_q <= S_RST;
    else if (Rdy) s_q <= s_d;
  end

  // A pop reads the slot above S; push and idle address S itself.
  assign StkAdr = (Stk_Op == STK_POP) ? {STK_PAGE, s_inc} : {STK_PAGE, s_q};
  assign S      = s_q;

endmodule

// File: rtl/m65c02_regfile.sv
// rtl/m65c02_regfile.sv - M65C02 architectural registers A/X/Y/S/P and operand read port
module m65c02_regfile
  import m65c02_pkg::*;
#(
  parameter logic [7:0] S_RST = S_RST_DEF,
  parameter logic [7:0] P_RST = P_RST_DEF
) (
  input  logic        Clk,
  input  logic        nRst,
  input  logic        Rdy,
  input  logic        SelA,
  input  logic        SelX,
  input  logic        SelY,
  input  logic        SelP,
  input  logic        SelS,
  input  logic [7:0]  Q,
  input  logic [7:0]  PSW_D,
  input  logic [1:0]  Stk_Op,
  input  logic        Int,
  input  logic [2:0]  OSel,
  output logic [7:0]  A,
  output logic [7:0]  X,
  output logic [7:0]  Y,
  output logic [7:0]  S,
  output logic [7:0]  P,
  output logic [7:0]  Out,
  output logic [15:0] StkAdr
);

  logic [7:0] a_q, x_q, y_q, p_q;
  logic [7:0] a_d, x_d, y_d, p_d;
  logic       unused_psw;

  assign unused_psw = ^PSW_D[5:4];

  // Interrupt entry is applied on top of the ALU status so it wins on I and D.
  always_comb begin
    a_d = SelA ? Q : a_q;
    x_d = SelX ? Q : x_q;
    y_d = SelY ? Q : y_q;
    p_d = SelP ? psw_merge(PSW_D) : p_q;
    if (Int) begin
      p_d[P_I] = 1'b1;
      p_d[P_D] = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      a_q <= 8'h00;
      x_q <= 8'h00;
      y_q <= 8'h00;
      p_q <= P_RST;
    end else if (Rdy) begin
      a_q <= a_d;
      x_q <= x_d;
      y_q <= y_d;
      p_q <= p_d;
    end
  end

  m65c02_stkptr #(.S_RST(S_RST)) u_stkptr (
    .Clk    (Clk),
    .nRst   (nRst),
    .Rdy    (Rdy),
    .Ld     (SelS),
    .Q      (Q),
    .Stk_Op (Stk_Op),
    .S      (S),
    .StkAdr (StkAdr)
  );

  always_comb begin
    Out = 8'h00;
    case (OSel)
      OS_A:    Out = a_q;
      OS_X:    Out = x_q;
      OS_Y:    Out = y_q;
      OS_S:    Out = S;
      OS_P:    Out = p_q;
      default: Out = 8'h00;
    endcase
  end

  assign A = a_q;
  assign X = x_q;
  assign Y = y_q;
  assign P = p_q;

endmodule

// File: tb/tb_m65c02_regfile.sv
// tb/tb_m65c02_regfile.sv - directed self-checking bench for m65c02_regfile
module tb_m65c02_regfile;

  logic        Clk = 1'b0;
  logic        nRst, Rdy, SelA, SelX, SelY, SelP, SelS, Int;
  logic [7:0]  Q, PSW_D;
  logic [1:0]  Stk_Op;
  logic [2:0]  OSel;
  logic [7:0]  A, X, Y, S, P, Out;
  logic [15:0] StkAdr;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  m65c02_regfile dut (
    .Clk(Clk), .nRst(nRst), .Rdy(Rdy),
    .SelA(SelA), .SelX(SelX), .SelY(SelY), .SelP(SelP), .SelS(SelS),
    .Q(Q), .PSW_D(PSW_D), .Stk_Op(Stk_Op), .Int(Int), .OSel(OSel),
    .A(A), .X(X), .Y(Y), .S(S), .P(P), .Out(Out), .StkAdr(StkAdr)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    SelA = 0; SelX = 0; SelY = 0; SelP = 0; SelS = 0;
    Int = 0; Stk_Op = 2'b00;
  endtask

  initial begin
    nRst = 0; Rdy = 1; Q = 8'h00; PSW_D = 8'h00; OSel = 3'd0;
    idle();
    #12 nRst = 1;

    SelA = 1; Q = 8'h5A;
    tick();
    idle();
    chk("a_pre_reset", {8'h00, A}, 16'h005A);

    #2 nRst = 0;
    #1;
    chk("rst_a", {8'h00, A}, 16'h0000);
    chk("rst_x", {8'h00, X}, 16'h0000);
    chk("rst_y", {8'h00, Y}, 16'h0000);
    chk("rst_s", {8'h00, S}, 16'h00FF);
    chk("rst_p", {8'h00, P}, 16'h0034);
    chk("rst_stkadr", StkAdr, 16'h01FF);
    #1 nRst = 1;

    SelA = 1; SelP = 1; Q = 8'h80; PSW_D = 8'h80;
    tick();
    idle();
    chk("lda_a", {8'h00, A}, 16'h0080);
    chk("lda_p", {8'h00, P}, 16'h00B0);
    OSel = 3'd0; #1;
    chk("lda_out_a", {8'h00, Out}, 16'h0080);
    OSel = 3'd4; #1;
    chk("lda_out_p", {8'h00, Out}, 16'h00B0);

    SelS = 1; Q = 8'h00;
    tick();
    idle();
    chk("txs_00", {8'h00, S}, 16'h0000);
    Stk_Op = 2'b01; #1;
    chk("push_adr_wrap", StkAdr, 16'h0100);
    tick();
    chk("push_wrap_s", {8'h00, S}, 16'h00FF);
    Stk_Op = 2'b10; #1;
    chk("pop_adr_wrap", StkAdr, 16'h0100);
    tick();
    Stk_Op = 2'b00; #1;
    chk("pop_wrap_s", {8'h00, S}, 16'h0000);

    SelS = 1; Q = 8'h10;
    tick();
    SelS = 1; Q = 8'h40; Stk_Op = 2'b01;
    tick();
    idle();
    chk("prio_txs", {8'h00, S}, 16'h0040);
    Stk_Op = 2'b01; #1;
    chk("push_adr", StkAdr, 16'h0140);
    tick();
    chk("push_s", {8'h00, S}, 16'h003F);
    Stk_Op = 2'b10; #1;
    chk("pop_adr", StkAdr, 16'h0140);
    tick();
    idle();
    chk("pop_s", {8'h00, S}, 16'h0040);
    Stk_Op = 2'b11; #1;
    chk("hold11_adr", StkAdr, 16'h0140);
    tick();
    idle();
    chk("hold11_s", {8'h00, S}, 16'h0040);

    SelP = 1; PSW_D = 8'h0F; Int = 1;
    tick();
    idle();
    chk("int_override", {8'h00, P}, 16'h0037);
    SelP = 1; PSW_D = 8'hFF;
    tick();
    idle();
    chk("p_ff", {8'h00, P}, 16'h00FF);
    Int = 1;
    tick();
    idle();
    chk("int_only", {8'h00, P}, 16'h00F7);

    Rdy = 0; SelX = 1; Q = 8'h33; Stk_Op = 2'b01; Int = 1; SelP = 1; PSW_D = 8'h00;
    tick();
    chk("stall_x", {8'h00, X}, 16'h0000);
    chk("stall_s", {8'h00, S}, 16'h0040);
    chk("stall_p", {8'h00, P}, 16'h00F7);
    idle();
    Rdy = 1; SelX = 1; Q = 8'h33;
    tick();
    idle();
    chk("resume_x", {8'h00, X}, 16'h0033);

    SelA = 1; SelX = 1; SelY = 1; Q = 8'hC3;
    tick();
    idle();
    chk("multi_a", {8'h00, A}, 16'h00C3);
    chk("multi_y", {8'h00, Y}, 16'h00C3);
    OSel = 3'd1; #1;
    chk("out_x", {8'h00, Out}, 16'h00C3);
    OSel = 3'd3; #1;
    chk("out_s", {8'h00, Out}, 16'h0040);
    OSel = 3'd5; #1;
    chk("out_5", {8'h00, Out}, 16'h0000);
    OSel = 3'd7; #1;
    chk("out_7", {8'h00, Out}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/m65c02_regfile.md
# m65c02_regfile

Architectural register file for the M65C02 core: the consumer of the registered write-select strobes (SelA/SelX/SelY/SelP/SelS) produced by the write-select decoder. It holds A, X, Y, S and P, commits the ALU result on the rising edge following a strobe, runs the stack pointer for push/pop, forces interrupt-entry flag changes and presents a selectable operand read port back to the ALU.

## Interface
Parameters:
- S_RST, 8'hFF, stack pointer value on reset.
- P_RST, 8'h34, processor status value on reset (M/bit5=1, B=1, I=1, D=0).

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- nRst  in  1  asynchronous, active-low reset.
- Rdy  in  1  clock enable; when 0 no register changes state.
- SelA, SelX, SelY, SelP, SelS  in  1 each  write strobes from the write-select decoder, stable from the preceding falling edge.
- Q  in  8  ALU result written to A/X/Y/S.
- PSW_D  in  8  new status from ALU, used when SelP=1.
- Stk_Op  in  2  00 hold, 01 push (S−1), 10 pop (S+1), 11 hold.
- Int  in  1  interrupt/BRK entry pulse: set I, clear D.
- OSel  in  3  read select: 0 A, 1 X, 2 Y, 3 S, 4 P, 5–7 8'h00.
- A, X, Y, S, P  out  8 each  architectural registers.
- Out  out  8  combinational read-port value selected by OSel.
- StkAdr  out  16  {8'h01, S} for push, {8'h01, S+1} for pop, {8'h01, S} otherwise.

## Operation
- Reset (nRst=0, asynchronous): A=X=Y=8'h00, S=S_RST, P=P_RST; held until nRst deasserts.
- A/X/Y: on rising edge with Rdy=1, each register loads Q when its strobe is 1; multiple strobes load the same Q.
- P: with Rdy=1 and SelP=1, P ← {PSW_D[7:6], 1'b1, 1'b1, PSW_D[3:0]}; bits 5 and 4 always read 1.
- Int=1 with Rdy=1: P[2] ← 1, P[3] ← 0, applied after the SelP update, so Int overrides PSW_D in those two bits only.
- S priority, highest first: SelS=1 loads Q (TXS); else Stk_Op=01 → S−1; else Stk_Op=10 → S+1; else hold.
- S arithmetic is 8-bit modulo: 8'h00 push → 8'hFF; 8'hFF pop → 8'h00. Page byte is always 8'h01.
- Read port and StkAdr are combinational from current register state: a write becomes visible on Out in the cycle after its edge, with no bypass.
- Strobes with Rdy=0 are ignored, not queued; the decoder re-presents them.

## Timing
- Write latency: strobe asserted (from decoder falling-edge register) → register updated at the next rising edge → visible on outputs immediately after that edge.
- One write per register per cycle; all register updates in the same edge are independent.
- Reset mid-operation: any in-progress push/pop or write is discarded; outputs take reset values asynchronously.
- nRst deassertion is synchronous to the system by upstream design; the first rising edge after release may perform a write.

## Structure
- Shared package m65c02_pkg: Stk_Op codes (STK_HOLD, STK_PUSH, STK_POP), OSel codes (OS_A…OS_P), P bit indices (P_N, P_V, P_B, P_D, P_I, P_Z, P_C), constants S_RST_DEF, P_RST_DEF, STK_PAGE = 8'h01.
- Sub-module m65c02_stkptr: S register, priority load/inc/dec, StkAdr generation.
- Top level holds A/X/Y/P and the read mux.

## Test plan
- Reset: drive nRst=0 mid-cycle with A=8'h5A → A=X=Y=00, S=FF, P=34 immediately, before any clock edge.
- LDA path: SelA=SelP=1, Q=8'h80, PSW_D=8'h80, Rdy=1 → next edge A=80, P=B0; OSel=0 gives Out=80.
- Stack wrap: S=00, Stk_Op=01 → S=FF, StkAdr was 0100 during the push; then Stk_Op=10 → StkAdr=0100 during the pop, S=00.
- Priority: SelS=1, Q=8'h40, Stk_Op=01, S=8'h10 → S=40 (push ignored).
- Int override: SelP=1, PSW_D=8'h0F, Int=1 → P=3F with bit3 cleared → P=37.
- Rdy stall: Rdy=0 with SelX=1, Q=8'h33 → X unchanged; Rdy=1 next cycle with strobe held → X=33.
